// File: rtl/position_pwm_driver.sv
// Position PWM driver: turns a signed position command into a fixed-frequency
// PWM pulse plus a direction line for the motor H-bridge. The duty is clamped
// to MAX_DUTY and is only reloaded at period boundaries. The first period after
// a direction reversal is blanked for DEAD_CYCLES clocks.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | driver disabled, counter parked at 0, output forced low
//  RUN   | normal period, pulse while cnt < duty
//  BLANK | first period after a reversal, pulse while DEAD <= cnt < duty
module position_pwm_driver #(
    parameter int PERIOD_CNT  = 1000,
    parameter int MAX_DUTY    = 900,
    parameter int DEAD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] Position_pwm,
    output logic        pwm_out,
    output logic        dir,
    output logic [15:0] duty_q,
    output logic        sat,
    output logic        period_start
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BLANK = 2'd2
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(PERIOD_CNT - 1);
    localparam logic [16:0] MAX_MAG  = 17'(MAX_DUTY);
    localparam logic [15:0] DEAD_CNT = 16'(DEAD_CYCLES);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] duty_d;
    logic        sat_q, sat_d;
    logic        dir_q, dir_d;
    logic        pwm_q, pwm_d;
    logic        ps_q, ps_d;

    logic [16:0] cmd_ext;
    logic [16:0] mag;
    logic        cmd_pos;
    logic        cmd_neg;

    // Magnitude in 17 bits so that -32768 maps to +32768 rather than wrapping.
    always_comb begin
        cmd_ext = {Position_pwm[15], Position_pwm};
        mag     = Position_pwm[15] ? (~cmd_ext + 17'd1) : cmd_ext;
        cmd_neg = Position_pwm[15];
        cmd_pos = !Position_pwm[15] && (Position_pwm != 16'd0);
    end

    // Next-state, counter, period-boundary sampling and pulse generation.
    // Outputs are derived from the next counter value so that pwm_out, dir and
    // period_start all line up with the registered counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        duty_d  = duty_q;
        sat_d   = sat_q;
        dir_d   = dir_q;
        pwm_d   = 1'b0;
        ps_d    = 1'b0;

        if (!en) begin
            state_d = IDLE;
            cnt_d   = 16'd0;
            duty_d  = 16'd0;
            sat_d   = 1'b0;
        end else if (state_q == IDLE) begin
            state_d = RUN;
            cnt_d   = 16'd0;
            duty_d  = 16'd0;
            sat_d   = 1'b0;
        end else if (cnt_q == LAST_CNT) begin
            cnt_d  = 16'd0;
            sat_d  = (mag > MAX_MAG);
            duty_d = (mag > MAX_MAG) ? MAX_MAG[15:0] : mag[15:0];
            if (cmd_pos) begin
                dir_d = 1'b1;
            end else if (cmd_neg) begin
                dir_d = 1'b0;
            end
            state_d = (dir_d != dir_q) ? BLANK : RUN;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end

        if (state_d != IDLE) begin
            ps_d = (cnt_d == 16'd0);
            if (state_d == BLANK) begin
                pwm_d = (cnt_d >= DEAD_CNT) && (cnt_d < duty_d);
            end else begin
                pwm_d = (cnt_d < duty_d);
            end
        end
    end

    // State and output registers; reset drops everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            duty_q  <= 16'd0;
            sat_q   <= 1'b0;
            dir_q   <= 1'b1;
            pwm_q   <= 1'b0;
            ps_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            sat_q   <= sat_d;
            dir_q   <= dir_d;
            pwm_q   <= pwm_d;
            ps_q    <= ps_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign dir          = dir_q;
    assign sat          = sat_q;
    assign period_start = ps_q;

endmodule

// File: tb/tb_position_pwm_driver.sv
// Directed bench for position_pwm_driver with a short 100-clock period.
module tb_position_pwm_driver;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] Position_pwm;
    logic        pwm_out;
    logic        dir;
    logic [15:0] duty_q;
    logic        sat;
    logic        period_start;

    int checks = 0;
    int errors = 0;

    position_pwm_driver #(
        .PERIOD_CNT (100),
        .MAX_DUTY   (90),
        .DEAD_CYCLES(5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .Position_pwm(Position_pwm),
        .pwm_out     (pwm_out),
        .dir         (dir),
        .duty_q      (duty_q),
        .sat         (sat),
        .period_start(period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag, input int e_duty, input int e_sat, input int e_dir);
        check({tag, "_ps"},   int'(period_start), 1);
        check({tag, "_duty"}, int'(duty_q),       e_duty);
        check({tag, "_sat"},  int'(sat),          e_sat);
        check({tag, "_dir"},  int'(dir),          e_dir);
    endtask

    // Observe one full period starting at the period_start sample point.
    // Optional mid-period command changes at counts c1/c2 (-1 = none).
    task automatic run_period(input string tag, input int e_first, input int e_n,
                              input int c1, input logic [15:0] v1,
                              input int c2, input logic [15:0] v2);
        int first;
        int last;
        int nhigh;
        int ps_bad;
        first  = -1;
        last   = -1;
        nhigh  = 0;
        ps_bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (pwm_out) begin
                if (first < 0) first = i;
                last = i;
                nhigh++;
            end
            if ((i == 0) != (period_start == 1'b1)) ps_bad++;
            if (i == c1) Position_pwm = v1;
            if (i == c2) Position_pwm = v2;
            @(negedge clk);
        end
        check({tag, "_nhigh"}, nhigh, e_n);
        if (e_n > 0) begin
            check({tag, "_first"}, first, e_first);
            check({tag, "_contig"}, last - first + 1, e_n);
        end
        check({tag, "_psbad"}, ps_bad, 0);
    endtask

    initial begin
        rst          = 1'b1;
        en           = 1'b0;
        Position_pwm = 16'd0;
        #1;
        check("rst_pwm",  int'(pwm_out),      0);
        check("rst_dir",  int'(dir),          1);
        check("rst_duty", int'(duty_q),       0);
        check("rst_sat",  int'(sat),          0);
        check("rst_ps",   int'(period_start), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_pwm", int'(pwm_out), 0);

        // Test 1: enable with +40, first period empty, then 40-clock pulses.
        Position_pwm = 16'd40;
        en           = 1'b1;
        @(negedge clk);
        chk_regs("p1", 0, 0, 1);
        run_period("p1", 0, 0, -1, 16'd0, -1, 16'd0);
        chk_regs("p2", 40, 0, 1);
        run_period("p2", 0, 40, -1, 16'd0, -1, 16'd0);

        // Test 2: reversal to -3000, blanked saturated period then full 90.
        Position_pwm = 16'hF448;
        chk_regs("p3", 40, 0, 1);
        run_period("p3", 0, 40, -1, 16'd0, -1, 16'd0);
        chk_regs("p4", 90, 1, 0);
        run_period("p4", 5, 85, -1, 16'd0, -1, 16'd0);
        Position_pwm = 16'h8000;
        chk_regs("p5", 90, 1, 0);
        run_period("p5", 0, 90, -1, 16'd0, -1, 16'd0);

        // Test 3: -32768 must not wrap; then zero command keeps direction.
        Position_pwm = 16'd0;
        chk_regs("p6", 90, 1, 0);
        run_period("p6", 0, 90, -1, 16'd0, -1, 16'd0);
        Position_pwm = 16'd20;
        chk_regs("p7", 0, 0, 0);
        run_period("p7", 0, 0, -1, 16'd0, -1, 16'd0);

        // Test 4: +20 (reversal, blanked), then mid-period glitches ignored.
        chk_regs("p8", 20, 0, 1);
        run_period("p8", 5, 15, -1, 16'd0, -1, 16'd0);
        chk_regs("p9", 20, 0, 1);
        run_period("p9", 0, 20, 50, 16'd70, 60, 16'd20);
        Position_pwm = 16'd40;
        chk_regs("p10", 20, 0, 1);
        run_period("p10", 0, 20, -1, 16'd0, -1, 16'd0);

        // Test 5: drop enable at cnt=10 mid-pulse.
        chk_regs("p11", 40, 0, 1);
        repeat (10) @(negedge clk);
        check("en_drop_pre_pwm", int'(pwm_out), 1);
        en = 1'b0;
        @(negedge clk);
        check("en_drop_pwm",  int'(pwm_out), 0);
        check("en_drop_duty", int'(duty_q),  0);
        check("en_drop_sat",  int'(sat),     0);
        check("en_drop_dir",  int'(dir),     1);
        repeat (3) @(negedge clk);
        check("idle2_ps",  int'(period_start), 0);
        check("idle2_pwm", int'(pwm_out),      0);
        en = 1'b1;
        @(negedge clk);
        chk_regs("e1", 0, 0, 1);
        run_period("e1", 0, 0, -1, 16'd0, -1, 16'd0);
        Position_pwm = 16'hFFD8;
        chk_regs("e2", 40, 0, 1);
        run_period("e2", 0, 40, -1, 16'd0, -1, 16'd0);
        chk_regs("e3", 40, 0, 0);
        run_period("e3", 5, 35, -1, 16'd0, -1, 16'd0);

        // Test 6: async reset at cnt=30 during a pulse with dir=0.
        chk_regs("e4", 40, 0, 0);
        repeat (30) @(negedge clk);
        check("rst2_pre_pwm", int'(pwm_out), 1);
        #2 rst = 1'b1;
        #1;
        check("rst2_pwm",  int'(pwm_out),      0);
        check("rst2_dir",  int'(dir),          1);
        check("rst2_duty", int'(duty_q),       0);
        check("rst2_ps",   int'(period_start), 0);
        @(negedge clk);
        @(negedge clk);
        check("rst2_hold_pwm", int'(pwm_out),      0);
        check("rst2_hold_ps",  int'(period_start), 0);
        rst = 1'b0;
        @(negedge clk);
        chk_regs("r1", 0, 0, 1);
        run_period("r1", 0, 0, -1, 16'd0, -1, 16'd0);
        chk_regs("r2", 40, 0, 0);
        run_period("r2", 5, 35, -1, 16'd0, -1, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
